// File: rtl/core_sequencer.sv
// Instruction sequencer: fetches from imem, broadcasts to all cores (1 instr / 2 cycles), and
// arbitrates the cores' host RAM port; optional SEQ_AUTO_SWAP_EN issues a buffer swap on HALT.
module core_sequencer #(
  parameter  int INSTRUCTION_WIDTH = 15,
  parameter  int ADDRESS_WIDTH     = 16,
  parameter  int PC_WIDTH          = 10,
  parameter  int NUM_CORES         = 4,
  localparam int SEL_WIDTH         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [PC_WIDTH-1:0]          start_pc,
  output logic                         imem_rd,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         issue_valid,
  input  logic                         host_req,
  input  logic [SEL_WIDTH-1:0]         host_sel,
  input  logic                         host_wren,
  input  logic [ADDRESS_WIDTH-1:0]     host_address,
  output logic                         host_gnt,
  output logic [NUM_CORES-1:0]         cpen,
  output logic                         wren,
  output logic [ADDRESS_WIDTH-1:0]     address,
  output logic                         busy,
  output logic                         done,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [15:0]                  instr_count
);

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(15'h0028);

`ifdef SEQ_AUTO_SWAP_EN
  localparam logic [INSTRUCTION_WIDTH-1:0] SWAP_OP = INSTRUCTION_WIDTH'(15'h0026);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_PAUSE, S_DONE, S_SWAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_PAUSE, S_DONE} state_t;
`endif

  state_t                         state_q, state_d;
  logic [PC_WIDTH-1:0]            pc_q, pc_d;
  logic [15:0]                    cnt_q, cnt_d;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
  logic                           iv_q, iv_d;
  logic                           is_halt;

  assign is_halt = ~imem_data[0] && (imem_data[5:1] == 5'b11111);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = NOP;
    iv_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !host_req) begin
          pc_d    = start_pc;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (is_halt) begin
`ifdef SEQ_AUTO_SWAP_EN
          instr_d = SWAP_OP;
          iv_d    = 1'b1;
          state_d = S_SWAP;
`else
          state_d = S_DONE;
`endif
        end else begin
          instr_d = imem_data;
          iv_d    = 1'b1;
          pc_d    = pc_q + PC_WIDTH'(1);
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          state_d = host_req ? S_PAUSE : S_FETCH;
        end
      end
      S_PAUSE: if (!host_req) state_d = S_FETCH;
`ifdef SEQ_AUTO_SWAP_EN
      S_SWAP: state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      instr_q <= NOP;
      iv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      iv_q    <= iv_d;
    end
  end

  assign imem_rd     = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign issue_valid = iv_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign done        = (state_q == S_DONE);
`ifdef SEQ_AUTO_SWAP_EN
  assign busy        = state_q inside {S_FETCH, S_EXEC, S_PAUSE, S_SWAP};
`else
  assign busy        = state_q inside {S_FETCH, S_EXEC, S_PAUSE};
`endif

  // Host owns the port only between fetch/issue pairs, never mid-pair.
  assign host_gnt = host_req && (state_q inside {S_IDLE, S_PAUSE, S_DONE});
  assign wren     = host_wren && host_gnt;
  assign address  = host_gnt ? host_address : '0;

  always_comb begin
    cpen = '0;
    for (int i = 0; i < NUM_CORES; i++)
      cpen[i] = host_gnt && (int'(host_sel) == i);
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed scenarios plus random programs checked
// against a program-walk reference model (issued word order, spacing, final pc/count).
module tb_core_sequencer;
  localparam int IW = 15, AW = 16, PW = 10, NC = 4;
  localparam logic [IW-1:0] NOP  = 15'h0028;
  localparam logic [IW-1:0] HALT = 15'h003E;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [PW-1:0] start_pc = '0;
  logic          imem_rd;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] instruction;
  logic          issue_valid;
  logic          host_req = 1'b0;
  logic [1:0]    host_sel = '0;
  logic          host_wren = 1'b0;
  logic [AW-1:0] host_address = '0;
  logic          host_gnt;
  logic [NC-1:0] cpen;
  logic          wren;
  logic [AW-1:0] address;
  logic          busy, done;
  logic [PW-1:0] pc;
  logic [15:0]   instr_count;

  // Three-core instance, used only to exercise an out-of-range host_sel.
  logic          b_imem_rd, b_issue_valid, b_host_gnt, b_wren, b_busy, b_done;
  logic [PW-1:0] b_imem_addr, b_pc;
  logic [IW-1:0] b_instruction;
  logic [2:0]    b_cpen;
  logic [AW-1:0] b_address;
  logic [15:0]   b_instr_count;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] mem [0:1023];
  logic [IW-1:0] prog [$];

  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  core_sequencer #(.INSTRUCTION_WIDTH(IW), .ADDRESS_WIDTH(AW), .PC_WIDTH(PW), .NUM_CORES(NC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .instruction(instruction), .issue_valid(issue_valid),
    .host_req(host_req), .host_sel(host_sel), .host_wren(host_wren), .host_address(host_address),
    .host_gnt(host_gnt), .cpen(cpen), .wren(wren), .address(address),
    .busy(busy), .done(done), .pc(pc), .instr_count(instr_count));

  core_sequencer #(.INSTRUCTION_WIDTH(IW), .ADDRESS_WIDTH(AW), .PC_WIDTH(PW), .NUM_CORES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(1'b0), .start_pc(start_pc),
    .imem_rd(b_imem_rd), .imem_addr(b_imem_addr), .imem_data(imem_data),
    .instruction(b_instruction), .issue_valid(b_issue_valid),
    .host_req(host_req), .host_sel(host_sel), .host_wren(host_wren), .host_address(host_address),
    .host_gnt(b_host_gnt), .cpen(b_cpen), .wren(b_wren), .address(b_address),
    .busy(b_busy), .done(b_done), .pc(b_pc), .instr_count(b_instr_count));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] rand_word();
    logic [IW-1:0] w;
    w = IW'($urandom);
    if (!w[0] && w[5:1] == 5'b11111) w[0] = 1'b1;
    return w;
  endfunction

  task automatic load(input logic [PW-1:0] spc, input logic [IW-1:0] halt);
    foreach (prog[i]) mem[PW'(int'(spc) + i)] = prog[i];
    mem[PW'(int'(spc) + prog.size())] = halt;
  endtask

  // Reference: the program issues its words in order, then (optionally) the swap op,
  // one every 2 cycles starting 2 cycles after start; pc stops on the HALT address.
  task automatic run(input logic [PW-1:0] spc, input bit rand_host, input logic [IW-1:0] halt);
    logic [IW-1:0] exp_q [$];
    logic [PW-1:0] exp_pc;
    int k = 0, cyc = 0;
    bit fin = 0;
    load(spc, halt);
    exp_q  = prog;
`ifdef SEQ_AUTO_SWAP_EN
    exp_q.push_back(15'h0026);
`endif
    exp_pc = PW'(int'(spc) + prog.size());
    @(negedge clk); start = 1'b1; start_pc = spc; host_req = 1'b0;
    while (cyc < 600 && !fin) begin
      @(negedge clk); cyc++; start = 1'b0;
      if (issue_valid) begin
        if (exp_q.size() == 0) check("extra_issue", 32'd1, 32'd0);
        else begin
          check("issue_instr", instruction, exp_q.pop_front());
          if (!rand_host) check("issue_cycle", cyc, 3 + 2 * k);
          k++;
        end
      end
      if (imem_rd) check("gnt_during_fetch", host_gnt, 0);
      if (done) fin = 1;
      else if (rand_host && $urandom_range(0, 3) == 0) host_req = ~host_req;
    end
    host_req = 1'b0;
    check("done_reached", fin, 1);
    check("final_pc", pc, exp_pc);
    check("final_count", instr_count, prog.size());
    check("final_instr", instruction, NOP);
    check("pending_issues", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    bit found;
    #12;
    check("rst_instr", instruction, NOP);
    check("rst_pc", pc, 0);
    check("rst_count", instr_count, 0);
    check("rst_iv", issue_valid, 0);
    check("rst_imem_rd", imem_rd, 0);
    check("rst_gnt", host_gnt, 0);
    check("rst_cpen", cpen, 0);
    check("rst_wren", wren, 0);
    check("rst_addr", address, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;

    // Host access while idle.
    @(negedge clk); host_req = 1'b1; host_sel = 2'd2; host_wren = 1'b1; host_address = 16'h0123;
    #1;
    check("idle_gnt", host_gnt, 1);
    check("idle_cpen", cpen, 4'b0100);
    check("idle_wren", wren, 1);
    check("idle_addr", address, 16'h0123);
    host_sel = 2'd3; host_wren = 1'b0; #1;
    check("top_cpen", cpen, 4'b1000);
    check("nowr_wren", wren, 0);
    check("oor_cpen", b_cpen, 3'b000);
    check("oor_gnt", b_host_gnt, 1);
    start = 1'b1;
    @(negedge clk);
    check("start_blocked_busy", busy, 0);
    start = 1'b0; host_req = 1'b0; #1;
    check("rel_gnt", host_gnt, 0);
    check("rel_cpen", cpen, 0);
    check("rel_addr", address, 0);

    // Basic program and pc wrap.
    prog = '{15'h0001, 15'h0003};
    run(10'd0, 0, HALT);
    prog = '{15'h0001};
    run(10'h3FF, 0, HALT);

    // Host pause between fetch/issue pairs.
    prog = {};
    for (int i = 0; i < 10; i++) prog.push_back(NOP);
    load(10'd0, HALT);
    host_sel = 2'd1;
    @(negedge clk); start = 1'b1; start_pc = 10'd0;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk); start = 1'b0;
      if (imem_rd && imem_addr == 10'd3) found = 1;
    end
    check("pause_found_fetch3", found, 1);
    host_req = 1'b1;
    @(negedge clk);
    check("pause_no_preempt", host_gnt, 0);
    @(negedge clk);
    check("pause_issue", issue_valid, 1);
    check("pause_issue_instr", instruction, NOP);
    check("pause_pc", pc, 4);
    check("pause_gnt", host_gnt, 1);
    check("pause_cpen", cpen, 4'b0010);
    repeat (2) begin
      @(negedge clk);
      check("pause_hold_iv", issue_valid, 0);
      check("pause_hold_gnt", host_gnt, 1);
      check("pause_hold_busy", busy, 1);
      check("pause_hold_rd", imem_rd, 0);
    end
    host_req = 1'b0;
    @(negedge clk);
    check("resume_rd", imem_rd, 1);
    check("resume_addr", imem_addr, 4);
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    check("pause_done", found, 1);
    check("pause_final_count", instr_count, 10);
    check("pause_final_pc", pc, 10);

    // Reset in the middle of execution.
    prog = {};
    for (int i = 0; i < 5; i++) prog.push_back(rand_word());
    load(10'd0, HALT);
    @(negedge clk); start = 1'b1; start_pc = 10'd0;
    repeat (4) begin @(negedge clk); start = 1'b0; end
    check("mid_count_before", instr_count, 1);
    rst_n = 1'b0; #1;
    check("mid_rst_instr", instruction, NOP);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", instr_count, 0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_rd", imem_rd, 0);
    @(negedge clk); rst_n = 1'b1; host_req = 1'b1; start = 1'b1;
    @(negedge clk);
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_done", done, 0);
    start = 1'b0; host_req = 1'b0;

    // Random programs, half with random host traffic.
    for (int r = 0; r < 8; r++) begin
      prog = {};
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) prog.push_back(rand_word());
      host_sel = 2'($urandom); host_wren = 1'($urandom); host_address = 16'($urandom);
      run(PW'($urandom), r[0], IW'({9'($urandom), 6'b111110}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
